// File: rtl/baseline_track.sv
// baseline_track
//   Learns the quiescent level of four independent vibration channels.  Each
//   channel averages fixed windows of 2^LOG2_N enabled samples and commits the
//   window mean as its baseline only when the window was quiet
//   (max - min <= QUIET_SPAN).  Noisy windows are discarded.
//
// Ports
//   clk                  in   1   system clock, rising edge
//   rst                  in   1   asynchronous reset, active low
//   relearn              in   1   sync pulse: drop all windows, clear valid flags
//   Ch{0..3}_Data        in   16  unsigned sample
//   Ch{0..3}_Data_en     in   1   sample strobe
//   Ch{0..3}_baseline    out  16  committed baseline
//   Ch{0..3}_base_valid  out  1   a baseline was committed since reset/relearn
//   Ch{0..3}_base_upd    out  1   1-cycle pulse: baseline just committed
//   Ch{0..3}_win_reject  out  1   1-cycle pulse: window ended noisy, discarded

// baseline_chan
//   One channel of the tracker.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_ACCUM | collecting samples of the current window
//   ST_CLOSE | window just closed; pulses visible, next sample still accepted
module baseline_chan #(
   parameter int          LOG2_N     = 6,
   parameter logic [15:0] QUIET_SPAN = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        relearn,
   input  logic [15:0] data,
   input  logic        data_en,
   output logic [15:0] baseline,
   output logic        base_valid,
   output logic        base_upd,
   output logic        win_reject
);

   localparam int ACC_W = 16 + LOG2_N;

   typedef enum logic {ST_ACCUM, ST_CLOSE} state_t;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [LOG2_N-1:0] cnt;
   logic [15:0]       wmin;
   logic [15:0]       wmax;

   logic [ACC_W-1:0]  sum_nxt;
   logic [15:0]       min_nxt;
   logic [15:0]       max_nxt;
   logic [15:0]       span;
   logic              last;
   logic              quiet;

   // Decision terms include the sample currently presented, so the closing
   // edge can commit without an extra cycle.
   always_comb begin
      sum_nxt = acc + {{LOG2_N{1'b0}}, data};
      min_nxt = (data < wmin) ? data : wmin;
      max_nxt = (data > wmax) ? data : wmax;
      span    = max_nxt - min_nxt;
      quiet   = (span <= QUIET_SPAN);
      last    = &cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_ACCUM;
         acc        <= '0;
         cnt        <= '0;
         wmin       <= 16'hFFFF;
         wmax       <= 16'h0000;
         baseline   <= 16'h0000;
         base_valid <= 1'b0;
         base_upd   <= 1'b0;
         win_reject <= 1'b0;
      end else begin
         base_upd   <= 1'b0;
         win_reject <= 1'b0;
         if (relearn) begin
            // Coincident strobe is dropped; baseline keeps its last value.
            state      <= ST_ACCUM;
            acc        <= '0;
            cnt        <= '0;
            wmin       <= 16'hFFFF;
            wmax       <= 16'h0000;
            base_valid <= 1'b0;
         end else if (data_en && last) begin
            state <= ST_CLOSE;
            acc   <= '0;
            cnt   <= '0;
            wmin  <= 16'hFFFF;
            wmax  <= 16'h0000;
            if (quiet) begin
               baseline   <= sum_nxt[ACC_W-1:LOG2_N];
               base_valid <= 1'b1;
               base_upd   <= 1'b1;
            end else begin
               win_reject <= 1'b1;
            end
         end else begin
            if (data_en) begin
               acc  <= sum_nxt;
               cnt  <= cnt + LOG2_N'(1);
               wmin <= min_nxt;
               wmax <= max_nxt;
            end
            if (state == ST_CLOSE) begin
               state <= ST_ACCUM;
            end
         end
      end
   end

endmodule

module baseline_track #(
   parameter int          LOG2_N     = 6,
   parameter logic [15:0] QUIET_SPAN = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        relearn,
   input  logic [15:0] Ch0_Data,
   input  logic        Ch0_Data_en,
   input  logic [15:0] Ch1_Data,
   input  logic        Ch1_Data_en,
   input  logic [15:0] Ch2_Data,
   input  logic        Ch2_Data_en,
   input  logic [15:0] Ch3_Data,
   input  logic        Ch3_Data_en,
   output logic [15:0] Ch0_baseline,
   output logic        Ch0_base_valid,
   output logic        Ch0_base_upd,
   output logic        Ch0_win_reject,
   output logic [15:0] Ch1_baseline,
   output logic        Ch1_base_valid,
   output logic        Ch1_base_upd,
   output logic        Ch1_win_reject,
   output logic [15:0] Ch2_baseline,
   output logic        Ch2_base_valid,
   output logic        Ch2_base_upd,
   output logic        Ch2_win_reject,
   output logic [15:0] Ch3_baseline,
   output logic        Ch3_base_valid,
   output logic        Ch3_base_upd,
   output logic        Ch3_win_reject
);

   baseline_chan #(.LOG2_N(LOG2_N), .QUIET_SPAN(QUIET_SPAN)) u_ch0 (
      .clk        (clk),
      .rst        (rst),
      .relearn    (relearn),
      .data       (Ch0_Data),
      .data_en    (Ch0_Data_en),
      .baseline   (Ch0_baseline),
      .base_valid (Ch0_base_valid),
      .base_upd   (Ch0_base_upd),
      .win_reject (Ch0_win_reject)
   );

   baseline_chan #(.LOG2_N(LOG2_N), .QUIET_SPAN(QUIET_SPAN)) u_ch1 (
      .clk        (clk),
      .rst        (rst),
      .relearn    (relearn),
      .data       (Ch1_Data),
      .data_en    (Ch1_Data_en),
      .baseline   (Ch1_baseline),
      .base_valid (Ch1_base_valid),
      .base_upd   (Ch1_base_upd),
      .win_reject (Ch1_win_reject)
   );

   baseline_chan #(.LOG2_N(LOG2_N), .QUIET_SPAN(QUIET_SPAN)) u_ch2 (
      .clk        (clk),
      .rst        (rst),
      .relearn    (relearn),
      .data       (Ch2_Data),
      .data_en    (Ch2_Data_en),
      .baseline   (Ch2_baseline),
      .base_valid (Ch2_base_valid),
      .base_upd   (Ch2_base_upd),
      .win_reject (Ch2_win_reject)
   );

   baseline_chan #(.LOG2_N(LOG2_N), .QUIET_SPAN(QUIET_SPAN)) u_ch3 (
      .clk        (clk),
      .rst        (rst),
      .relearn    (relearn),
      .data       (Ch3_Data),
      .data_en    (Ch3_Data_en),
      .baseline   (Ch3_baseline),
      .base_valid (Ch3_base_valid),
      .base_upd   (Ch3_base_upd),
      .win_reject (Ch3_win_reject)
   );

endmodule

// File: tb/tb_baseline_track.sv
// tb_baseline_track
//   Bench for baseline_track with LOG2_N=3 (8-sample windows), QUIET_SPAN=16.
//   Each driven cycle pushes its expected outputs; they are popped and compared
//   one edge later, once the DUT has sampled the stimulus.
module tb_baseline_track;

   logic        clk;
   logic        rst;
   logic        relearn;
   logic [15:0] data     [4];
   logic        data_en  [4];
   logic [15:0] base     [4];
   logic        bvalid   [4];
   logic        bupd     [4];
   logic        wrej     [4];

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]       en;
      logic [3:0][15:0] d;
      logic             rl;
      logic [3:0]       upd;
      logic [3:0]       rej;
      logic [3:0]       valid;
      logic [3:0][15:0] base;
   } vec_t;

   vec_t tbl [$];
   vec_t sb  [$];

   logic [3:0][15:0] exp_b;
   logic [3:0]       exp_v;

   baseline_track #(.LOG2_N(3), .QUIET_SPAN(16'd16)) dut (
      .clk            (clk),
      .rst            (rst),
      .relearn        (relearn),
      .Ch0_Data       (data[0]),
      .Ch0_Data_en    (data_en[0]),
      .Ch1_Data       (data[1]),
      .Ch1_Data_en    (data_en[1]),
      .Ch2_Data       (data[2]),
      .Ch2_Data_en    (data_en[2]),
      .Ch3_Data       (data[3]),
      .Ch3_Data_en    (data_en[3]),
      .Ch0_baseline   (base[0]),
      .Ch0_base_valid (bvalid[0]),
      .Ch0_base_upd   (bupd[0]),
      .Ch0_win_reject (wrej[0]),
      .Ch1_baseline   (base[1]),
      .Ch1_base_valid (bvalid[1]),
      .Ch1_base_upd   (bupd[1]),
      .Ch1_win_reject (wrej[1]),
      .Ch2_baseline   (base[2]),
      .Ch2_base_valid (bvalid[2]),
      .Ch2_base_upd   (bupd[2]),
      .Ch2_win_reject (wrej[2]),
      .Ch3_baseline   (base[3]),
      .Ch3_base_valid (bvalid[3]),
      .Ch3_base_upd   (bupd[3]),
      .Ch3_win_reject (wrej[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] on_ch(input int c, input logic [15:0] v);
      return 64'(v) << (16 * c);
   endfunction

   function automatic void add(input logic [3:0] en, input logic [63:0] d,
                               input logic rl, input logic [3:0] upd,
                               input logic [3:0] rej, input logic [3:0] valid,
                               input logic [63:0] b);
      vec_t v;
      v.en = en; v.d = d; v.rl = rl;
      v.upd = upd; v.rej = rej; v.valid = valid; v.base = b;
      tbl.push_back(v);
   endfunction

   task automatic compare(input string tag);
      vec_t e;
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (base[c] !== e.base[c] || bvalid[c] !== e.valid[c] ||
             bupd[c] !== e.upd[c] || wrej[c] !== e.rej[c]) begin
            errors++;
            $display("FAIL %s ch%0d: got base=%0d valid=%b upd=%b rej=%b, expected base=%0d valid=%b upd=%b rej=%b",
                     tag, c, base[c], bvalid[c], bupd[c], wrej[c],
                     e.base[c], e.valid[c], e.upd[c], e.rej[c]);
         end
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      for (int c = 0; c < 4; c++) begin
         data_en[c] = v.en[c];
         data[c]    = v.d[c];
      end
      relearn = v.rl;
      sb.push_back(v);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic step(input logic [3:0] en, input logic [63:0] d, input logic rl,
                       input logic [3:0] upd, input logic [3:0] rej, input string tag);
      vec_t v;
      v.en = en; v.d = d; v.rl = rl;
      v.upd = upd; v.rej = rej; v.valid = exp_v; v.base = exp_b;
      apply(v, tag);
   endtask

   task automatic check_zero(input string tag);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (base[c] !== 16'd0 || bvalid[c] !== 1'b0 || bupd[c] !== 1'b0 || wrej[c] !== 1'b0) begin
            errors++;
            $display("FAIL %s ch%0d: got base=%0d valid=%b upd=%b rej=%b, expected all zero",
                     tag, c, base[c], bvalid[c], bupd[c], wrej[c]);
         end
      end
   endtask

   initial begin
      // Test 1: ch0 ramp 1000..1007 -> 8028>>3 = 1003
      for (int i = 0; i < 7; i++)
         add(4'b0001, on_ch(0, 16'(1000 + i)), 1'b0, 4'b0, 4'b0, 4'b0000, 64'd0);
      add(4'b0001, on_ch(0, 16'd1007), 1'b0, 4'b0001, 4'b0, 4'b0001, on_ch(0, 16'd1003));
      add(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, 4'b0001, on_ch(0, 16'd1003));
      // Test 2: ch1 span 17 rejected, span 16 accepted ((7*500+516)>>3 = 502)
      for (int i = 0; i < 7; i++)
         add(4'b0010, on_ch(1, 16'd500), 1'b0, 4'b0, 4'b0, 4'b0001, on_ch(0, 16'd1003));
      add(4'b0010, on_ch(1, 16'd517), 1'b0, 4'b0, 4'b0010, 4'b0001, on_ch(0, 16'd1003));
      add(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, 4'b0001, on_ch(0, 16'd1003));
      for (int i = 0; i < 7; i++)
         add(4'b0010, on_ch(1, 16'd500), 1'b0, 4'b0, 4'b0, 4'b0001, on_ch(0, 16'd1003));
      add(4'b0010, on_ch(1, 16'd516), 1'b0, 4'b0010, 4'b0, 4'b0011,
          {32'd0, 16'd502, 16'd1003});
      add(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, 4'b0011, {32'd0, 16'd502, 16'd1003});
      // Test 3: all channels together, including full-scale
      for (int i = 0; i < 7; i++)
         add(4'b1111, {16'hFFFF, 16'd300, 16'd200, 16'd100}, 1'b0, 4'b0, 4'b0,
             4'b0011, {32'd0, 16'd502, 16'd1003});
      add(4'b1111, {16'hFFFF, 16'd300, 16'd200, 16'd100}, 1'b0, 4'b1111, 4'b0,
          4'b1111, {16'hFFFF, 16'd300, 16'd200, 16'd100});
      add(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, 4'b1111, {16'hFFFF, 16'd300, 16'd200, 16'd100});

      rst     = 1'b0;
      relearn = 1'b0;
      for (int c = 0; c < 4; c++) begin
         data[c]    = 16'd0;
         data_en[c] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("tbl[%0d]", i));

      exp_b = {16'hFFFF, 16'd300, 16'd200, 16'd100};
      exp_v = 4'b1111;

      // Test 4: ch2 quiet at 2000, relearn on 5th strobe of next window
      for (int i = 0; i < 7; i++) step(4'b0100, on_ch(2, 16'd2000), 1'b0, 4'b0, 4'b0, "t4_fill");
      exp_b[2] = 16'd2000;
      step(4'b0100, on_ch(2, 16'd2000), 1'b0, 4'b0100, 4'b0, "t4_commit");
      for (int i = 0; i < 4; i++) step(4'b0100, on_ch(2, 16'd2008), 1'b0, 4'b0, 4'b0, "t4_part");
      exp_v = 4'b0000;
      step(4'b0100, on_ch(2, 16'd2008), 1'b1, 4'b0, 4'b0, "t4_relearn");
      for (int i = 0; i < 7; i++) step(4'b0100, on_ch(2, 16'd2008), 1'b0, 4'b0, 4'b0, "t4_refill");
      exp_b[2] = 16'd2008;
      exp_v[2] = 1'b1;
      step(4'b0100, on_ch(2, 16'd2008), 1'b0, 4'b0100, 4'b0, "t4_recommit");
      step(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, "t4_idle");

      // Test 5: ch3 back-to-back (24028>>3=3003), then with random gaps (24828>>3=3103)
      for (int i = 0; i < 7; i++)
         step(4'b1000, on_ch(3, 16'(3000 + i)), 1'b0, 4'b0, 4'b0, "t5_b2b");
      exp_b[3] = 16'd3003;
      exp_v[3] = 1'b1;
      step(4'b1000, on_ch(3, 16'd3007), 1'b0, 4'b1000, 4'b0, "t5_b2b_commit");
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = int'($urandom_range(0, 5));
         for (int g = 0; g < gap; g++)
            step(4'b0000, on_ch(3, 16'hDEAD), 1'b0, 4'b0, 4'b0, "t5_gap");
         if (i == 7) begin
            exp_b[3] = 16'd3103;
            step(4'b1000, on_ch(3, 16'd3107), 1'b0, 4'b1000, 4'b0, "t5_gap_commit");
         end else begin
            step(4'b1000, on_ch(3, 16'(3100 + i)), 1'b0, 4'b0, 4'b0, "t5_gap_fill");
         end
      end
      step(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, "t5_idle");

      // Test 6: async reset mid-window, then a fresh full window of 70
      for (int i = 0; i < 4; i++) step(4'b0001, on_ch(0, 16'd50), 1'b0, 4'b0, 4'b0, "t6_part");
      rst = 1'b0;
      #1;
      check_zero("t6_async_rst");
      exp_b = '0;
      exp_v = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 7; i++) step(4'b0001, on_ch(0, 16'd70), 1'b0, 4'b0, 4'b0, "t6_fill");
      exp_b[0] = 16'd70;
      exp_v[0] = 1'b1;
      step(4'b0001, on_ch(0, 16'd70), 1'b0, 4'b0001, 4'b0, "t6_commit");
      step(4'b0000, 64'd0, 1'b0, 4'b0, 4'b0, "t6_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
